// File: rtl/week_5_xor_frame_parity.sv
// XOR-accumulates FRAME_LEN words per frame. It returns the column-parity word and the frame parity bit.
// Optional build macro WEEK5_PARITY_CHECK_EN adds the exp_parity input and the out_err mismatch flag.
module week_5_xor_frame_parity #(
  parameter int WIDTH     = 8,
  parameter int FRAME_LEN = 4,
  parameter int ODD       = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_lane,
`ifdef WEEK5_PARITY_CHECK_EN
  input  logic             exp_parity,
  output logic             out_err,
`endif
  output logic             out_parity
);

  localparam int                CNT_W    = $clog2(FRAME_LEN + 1);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam bit                ODD_B    = (ODD != 0);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;
  logic             last_word;
  logic [WIDTH-1:0] lane_next;

  assign accept    = in_valid && in_ready;
  assign last_word = ((state_q == IDLE) && (FRAME_LEN == 1)) ||
                     ((state_q == ACCUM) && (cnt_q == LAST_CNT));
  // The first word of a frame overwrites the accumulator instead of XORing into it.
  assign lane_next = (state_q == IDLE) ? in_data : (acc_q ^ in_data);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (accept) state_d = (FRAME_LEN == 1) ? DONE : ACCUM;
        ACCUM:   if (accept && last_word) state_d = DONE;
        DONE:    if (out_ready) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready   = !rst && (state_q != DONE);
    out_valid  = (state_q == DONE);
    out_lane   = out_valid ? acc_q : '0;
    out_parity = out_valid ? ((^acc_q) ^ ODD_B) : 1'b0;
  end

  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (clr) begin
      acc_d = '0;
      cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          acc_d = lane_next;
          cnt_d = CNT_ONE;
        end
        ACCUM: if (accept) begin
          acc_d = lane_next;
          cnt_d = cnt_q + CNT_ONE;
        end
        DONE: if (out_ready) begin
          acc_d = '0;
          cnt_d = '0;
        end
        default: begin
          acc_d = '0;
          cnt_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

`ifdef WEEK5_PARITY_CHECK_EN
  logic err_q, err_d;

  // The mismatch is captured on the edge that closes the frame, together with out_valid.
  always_comb begin
    err_d = err_q;
    if (clr) begin
      err_d = 1'b0;
    end else if (accept && last_word) begin
      err_d = (exp_parity != ((^lane_next) ^ ODD_B));
    end else if ((state_q == DONE) && out_ready) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign out_err = out_valid && err_q;
`endif

endmodule
